serial_alu_seq: RTL and testbench

- Bit-serial execution sequencer that drives the serial register file: consumer of its rs1/rs2 bit streams and producer of its write-bit stream.
- Accepts one ALU operation per valid/ready handshake.
- Asserts shift_en for exactly REG_WIDTH cycles, computes the result LSB-first with a one-bit carry, streams it back with wr_en, then pulses done with updated flags.

---
 rtl/serial_alu_seq_if.sv | 23 ++
 rtl/serial_alu_seq.sv | 164 ++++++++++++++++
 tb/tb_serial_alu_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_seq_if.sv
// Operation request channel between an issuing controller and the bit-serial sequencer.
// Plain valid/ready: a request is taken on the edge where op_valid and op_ready are both high.
interface serial_alu_seq_if #(
  parameter int ADDR_W = 3
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic              op_wb;
  logic [ADDR_W-1:0] op_rs1;
  logic [ADDR_W-1:0] op_rs2;
  logic [ADDR_W-1:0] op_rd;

  modport master (
    output op_valid, op_code, op_wb, op_rs1, op_rs2, op_rd,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_code, op_wb, op_rs1, op_rs2, op_rd,
    output op_ready
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer streaming LSB-first through a rotating regfile; REG_WIDTH shift cycles plus one done cycle.
// Backpressure: op_ready is high only in IDLE, so a new request waits REG_WIDTH+2 cycles behind the previous one.
module serial_alu_seq #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rstn,
  serial_alu_seq_if.slave   op,
  output logic              shift_en,
  output logic [ADDR_W-1:0] rs1_addr,
  output logic [ADDR_W-1:0] rs2_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rs1_bit,
  input  logic              rs2_bit,
  output logic              wr_bit,
  output logic              wr_en,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int CNT_W = $clog2(REG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MOV1 = 3'b101,
    OP_CMP  = 3'b110,
    OP_MOV2 = 3'b111
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    opc_t              code;
    logic              wb;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
  } op_t;

  state_t            state;
  state_t            state_nxt;
  op_t               op_q;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  logic              zacc;
  logic              ready;
  logic              accept;
  logic              last_bit;
  logic              is_arith;
  logic              is_sub;
  logic              b_in;
  logic              sum;
  logic              cout;
  logic              res;

  assign op.op_ready = ready;
  assign accept      = op.op_valid & ready;
  assign last_bit    = (cnt == CNT_LAST);

  assign is_sub   = (op_q.code == OP_SUB) || (op_q.code == OP_CMP);
  assign is_arith = is_sub || (op_q.code == OP_ADD);

  assign rs1_addr = op_q.rs1;
  assign rs2_addr = op_q.rs2;
  assign rd_addr  = op_q.rd;

  // Subtraction is rs1 + ~rs2 with the carry pre-seeded to 1 at acceptance.
  always_comb begin
    b_in = is_sub ? ~rs2_bit : rs2_bit;
    sum  = rs1_bit ^ b_in ^ carry;
    cout = (rs1_bit & b_in) | (carry & (rs1_bit ^ b_in));
    case (op_q.code)
      OP_ADD, OP_SUB, OP_CMP: res = sum;
      OP_AND:                 res = rs1_bit & rs2_bit;
      OP_OR:                  res = rs1_bit | rs2_bit;
      OP_XOR:                 res = rs1_bit ^ rs2_bit;
      OP_MOV1:                res = rs1_bit;
      OP_MOV2:                res = rs2_bit;
      default:                res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  ready    = 1'b1;
      ST_SHIFT: shift_en = 1'b1;
      ST_DONE:  done     = 1'b1;
      default:  ready    = 1'b0;
    endcase
  end

  // Reading and writing the same bit position in one cycle makes rd==rs1/rs2 safe.
  assign wr_en  = shift_en & op_q.wb & (op_q.code != OP_CMP);
  assign wr_bit = shift_en & res;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      op_q.code <= opc_t'(op.op_code);
      op_q.wb   <= op.op_wb;
      op_q.rs1  <= op.op_rs1;
      op_q.rs2  <= op.op_rs2;
      op_q.rd   <= op.op_rd;
      cnt       <= '0;
      carry     <= (op.op_code == OP_SUB) || (op.op_code == OP_CMP);
      zacc      <= 1'b1;
    end else if (state == ST_SHIFT) begin
      carry <= cout;
      zacc  <= zacc & ~res;
      if (last_bit) begin
        // Flags are committed on the MSB edge so they are valid alongside done.
        flag_z <= zacc & ~res;
        flag_n <= res;
        flag_c <= is_arith & cout;
        flag_v <= is_arith & (carry ^ cout);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a rotating 8x8 regfile model and a result scoreboard.
module tb_serial_alu_seq;
  localparam int RW = 8;
  localparam int AW = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  serial_alu_seq_if #(.ADDR_W(AW)) opif();

  logic          shift_en, wr_bit, wr_en, done;
  logic          flag_z, flag_n, flag_c, flag_v;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic          rs1_bit, rs2_bit;

  serial_alu_seq #(.REG_WIDTH(RW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .op       (opif),
    .shift_en (shift_en),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rs1_bit  (rs1_bit),
    .rs2_bit  (rs2_bit),
    .wr_bit   (wr_bit),
    .wr_en    (wr_en),
    .done     (done),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  // Rotating regfile: every addressed register shifts right; rd takes wr_bit at the MSB.
  logic [7:0]    rf [8];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a  = '0;
  logic [7:0]    ld_d  = '0;

  assign rs1_bit = rf[rs1_addr][0];
  assign rs2_bit = rf[rs2_addr][0];

  always @(posedge clk) begin
    if (ld_en) begin
      rf[ld_a] <= ld_d;
    end else if (shift_en) begin
      for (int r = 0; r < 8; r++) begin
        if (3'(r) == rs1_addr || 3'(r) == rs2_addr || 3'(r) == rd_addr)
          rf[r] <= {(wr_en && 3'(r) == rd_addr) ? wr_bit : rf[r][0], rf[r][7:1]};
      end
    end
  end

  typedef struct {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       wr;
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [2:0] code, input logic wb,
                                   input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
    exp_t       e;
    logic [7:0] a, b, r;
    logic [8:0] s;
    logic       c, v;
    a = rf[s1]; b = rf[s2]; r = '0; s = '0; c = 1'b0; v = 1'b0;
    case (code)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'b001, 3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = a;
      default: r = b;
    endcase
    e.rs1   = s1;
    e.rs2   = s2;
    e.rd    = d;
    e.wr    = wb && (code != 3'b110);
    e.res   = e.wr ? r : rf[d];
    e.flags = {(r == 8'h00), r[7], c, v};
    return e;
  endfunction

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Drives a request, records its expectation and returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] code, input logic wb, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [2:0] d, input bit keep);
    int n;
    @(negedge clk);
    opif.op_code = code; opif.op_wb = wb;
    opif.op_rs1 = s1; opif.op_rs2 = s2; opif.op_rd = d;
    opif.op_valid = 1'b1;
    sbq.push_back(predict(code, wb, s1, s2, d));
    n = 0;
    while (!opif.op_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) opif.op_valid = 1'b0;
  endtask

  // Follows one operation from acceptance to done and retires its scoreboard entry.
  task automatic track(input string tag);
    exp_t e;
    int   shifts, wrs, ready_hi, addr_bad, done_k;
    shifts = 0; wrs = 0; ready_hi = 0; addr_bad = 0; done_k = -1;
    chk($sformatf("%s_sbq", tag), 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() == 0) return;
    e = sbq[0];
    for (int k = 1; k <= 30 && done_k < 0; k++) begin
      @(negedge clk);
      if (shift_en) shifts++;
      if (wr_en) wrs++;
      if (opif.op_ready) ready_hi++;
      if (rs1_addr !== e.rs1 || rs2_addr !== e.rs2 || rd_addr !== e.rd) addr_bad++;
      if (done) done_k = k;
    end
    e = sbq.pop_front();
    chk($sformatf("%s_shift_cycles", tag), shifts, RW);
    chk($sformatf("%s_done_at", tag), done_k, RW + 1);
    chk($sformatf("%s_wr_cycles", tag), wrs, e.wr ? RW : 0);
    chk($sformatf("%s_ready_busy", tag), ready_hi, 0);
    chk($sformatf("%s_addr_hold", tag), addr_bad, 0);
    chk($sformatf("%s_flags_zncv", tag), {flag_z, flag_n, flag_c, flag_v}, e.flags);
    chk($sformatf("%s_rd_value", tag), rf[e.rd], e.res);
  endtask

  initial begin
    int done_seen;
    opif.op_valid = 1'b0; opif.op_code = '0; opif.op_wb = 1'b0;
    opif.op_rs1 = '0; opif.op_rs2 = '0; opif.op_rd = '0;

    #1;
    chk("rst_ready", opif.op_ready, 1'b1);
    chk("rst_outputs", {shift_en, wr_en, wr_bit, done}, 4'b0000);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    chk("rst_addrs", {rs1_addr, rs2_addr, rd_addr}, 9'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {opif.op_ready, shift_en, done}, 3'b100);

    // ADD with signed overflow into r3.
    load(3'd1, 8'h7F); load(3'd2, 8'h01); load(3'd3, 8'h00);
    issue(3'b000, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0);
    track("add");
    chk("add_r3_const", rf[3], 8'h80);
    chk("add_flags_const", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);

    // In-place SUB r4 = r4 - r4.
    load(3'd4, 8'h05);
    issue(3'b001, 1'b1, 3'd4, 3'd4, 3'd4, 1'b0);
    track("sub_inplace");
    chk("sub_flags_const", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);

    // CMP never writes; sources rotate back unchanged.
    load(3'd1, 8'h03); load(3'd2, 8'h04); load(3'd5, 8'h5C);
    issue(3'b110, 1'b1, 3'd1, 3'd2, 3'd5, 1'b0);
    track("cmp");
    chk("cmp_r1_kept", rf[1], 8'h03);
    chk("cmp_r2_kept", rf[2], 8'h04);
    chk("cmp_flags_const", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);

    // XOR without writeback, then MOV1 with writeback.
    load(3'd6, 8'hA5); load(3'd7, 8'hFF); load(3'd0, 8'h3C);
    issue(3'b100, 1'b0, 3'd6, 3'd7, 3'd0, 1'b0);
    track("xor_nowb");
    chk("xor_dest_kept", rf[0], 8'h3C);
    issue(3'b101, 1'b1, 3'd6, 3'd7, 3'd0, 1'b0);
    track("mov1");
    chk("mov1_dest", rf[0], 8'hA5);
    chk("mov1_flags_const", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);

    // Reset in the middle of an ADD.
    load(3'd1, 8'h11); load(3'd2, 8'h22);
    issue(3'b000, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_add_busy", {shift_en, wr_en}, 2'b11);
    #1 rstn = 1'b0;
    #1;
    chk("async_drop", {shift_en, wr_en, opif.op_ready}, 3'b001);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);
    chk("rst_flags_cleared", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    chk("rst_ready_back", opif.op_ready, 1'b1);
    chk("rst_rd_addr", rd_addr, 3'd0);
    sbq.delete();
    load(3'd1, 8'h11); load(3'd2, 8'h22);
    issue(3'b000, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0);
    track("add_after_rst");
    chk("add_after_rst_r3", rf[3], 8'h33);

    // op_valid held across two requests; second fields appear while the first is shifting.
    load(3'd5, 8'h10); load(3'd6, 8'h20); load(3'd0, 8'h0F);
    issue(3'b000, 1'b1, 3'd5, 3'd6, 3'd7, 1'b1);
    opif.op_code = 3'b011; opif.op_wb = 1'b1;
    opif.op_rs1 = 3'd0; opif.op_rs2 = 3'd5; opif.op_rd = 3'd2;
    sbq.push_back(predict(3'b011, 1'b1, 3'd0, 3'd5, 3'd2));
    track("b2b_first");
    @(negedge clk);
    chk("b2b_ready_t10", opif.op_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("b2b_accept_t10", shift_en, 1'b1);
    opif.op_valid = 1'b0;
    track("b2b_second");
    chk("b2b_r7", rf[7], 8'h30);
    chk("b2b_r2", rf[2], 8'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
